// File: rtl/vga_sync_rx.sv
// vga_sync_rx: recovers pixel position, line/frame measurements and a lock flag from
// incoming active-low VGA hsync/vsync sampled on pixel-enable ticks.
// Optional feature: define VGA_RX_STATS_EN to enable the saturating err_count counter;
// without it err_count is tied to zero.
module vga_sync_rx #(
    parameter int unsigned H_TOTAL     = 800,
    parameter int unsigned V_TOTAL     = 525,
    parameter int unsigned H_START     = 144,
    parameter int unsigned V_START     = 35,
    parameter int unsigned LOCK_FRAMES = 2,
    parameter int unsigned H_ACTIVE    = 640,
    parameter int unsigned V_ACTIVE    = 480
) (
    input  logic        clk_100MHz,
    input  logic        reset_n,
    input  logic        p_tick,
    input  logic        hsync,
    input  logic        vsync,
    output logic [9:0]  x,
    output logic [9:0]  y,
    output logic        video_on,
    output logic        locked,
    output logic        frame_start,
    output logic        h_err,
    output logic        v_err,
    output logic [9:0]  line_len,
    output logic [9:0]  frame_lines,
    output logic [15:0] err_count
);

    localparam int unsigned LCW = (LOCK_FRAMES < 1) ? 1 : $clog2(LOCK_FRAMES + 1);

    localparam logic [9:0]     CNT_MAX = 10'd1023;
    localparam logic [9:0]     CNT_PRE = 10'd1022;
    localparam logic [9:0]     H_BEG   = 10'(H_START);
    localparam logic [9:0]     V_BEG   = 10'(V_START);
    localparam logic [10:0]    H_END   = 11'(H_START + H_ACTIVE);
    localparam logic [10:0]    V_END   = 11'(V_START + V_ACTIVE);
    localparam logic [10:0]    H_TOT   = 11'(H_TOTAL);
    localparam logic [10:0]    V_TOT   = 11'(V_TOTAL);
    localparam logic [LCW-1:0] LOCK_N  = LCW'(LOCK_FRAMES);

    typedef enum logic [1:0] {
        StSearch,
        StAcquire,
        StLocked
    } state_e;

    state_e         r_state, w_state_next;
    logic [LCW-1:0] r_good_cnt, w_good_next, w_good_inc;

    logic       r_hs_q, r_vs_q;
    logic [9:0] r_hcnt, r_vcnt;
    logic [9:0] r_line_len, r_frame_lines;
    logic       r_frame_bad;
    logic       r_locked;
    logic       r_h_err, r_v_err, r_frame_start;

    logic        w_h_fall, w_v_fall;
    logic [9:0]  w_hcnt_inc, w_vcnt_inc;
    logic [10:0] w_h_period, w_v_period;
    logic        w_h_err_now, w_v_err_now, w_err;
    logic        w_clean;
    logic        w_h_act, w_v_act, w_act;

    assign w_h_fall   = p_tick & r_hs_q & ~hsync;
    assign w_v_fall   = p_tick & r_vs_q & ~vsync;
    assign w_hcnt_inc = r_hcnt + 10'd1;
    assign w_vcnt_inc = r_vcnt + 10'd1;
    // Periods kept one bit wider so a saturated counter never aliases a legal period.
    assign w_h_period = {1'b0, r_hcnt} + 11'd1;
    assign w_v_period = {1'b0, r_vcnt} + 11'd1;

    // Timeout fires only on the tick that moves a counter from 1022 to 1023.
    assign w_h_err_now = w_h_fall ? (w_h_period != H_TOT) : (p_tick && (r_hcnt == CNT_PRE));
    assign w_v_err_now = w_v_fall ? (w_v_period != V_TOT) : (w_h_fall && (r_vcnt == CNT_PRE));
    assign w_err       = w_h_err_now | w_v_err_now;
    assign w_clean     = ~r_frame_bad & (w_v_period == V_TOT);
    assign w_good_inc  = r_good_cnt + LCW'(1);

    // Lock state machine: next state and good-frame count.
    always_comb begin
        w_state_next = r_state;
        w_good_next  = r_good_cnt;
        unique case (r_state)
            StSearch: begin
                if (w_v_fall) begin
                    w_state_next = StAcquire;
                    w_good_next  = '0;
                end
            end
            StAcquire: begin
                if (w_err) begin
                    w_state_next = StSearch;
                end else if (w_v_fall && w_clean) begin
                    w_good_next = w_good_inc;
                    if (w_good_inc == LOCK_N) begin
                        w_state_next = StLocked;
                    end
                end
            end
            StLocked: begin
                if (w_err) begin
                    w_state_next = StSearch;
                end
            end
            default: w_state_next = StSearch;
        endcase
    end

    // Lock state machine: state register.
    always_ff @(posedge clk_100MHz) begin
        if (!reset_n) begin
            r_state    <= StSearch;
            r_good_cnt <= '0;
        end else begin
            r_state    <= w_state_next;
            r_good_cnt <= w_good_next;
        end
    end

    // Sync sampling, position counters, measurements and pulse outputs.
    always_ff @(posedge clk_100MHz) begin
        if (!reset_n) begin
            r_hs_q        <= 1'b1;
            r_vs_q        <= 1'b1;
            r_hcnt        <= '0;
            r_vcnt        <= '0;
            r_line_len    <= '0;
            r_frame_lines <= '0;
            r_frame_bad   <= 1'b0;
            r_locked      <= 1'b0;
            r_h_err       <= 1'b0;
            r_v_err       <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_h_err       <= w_h_err_now;
            r_v_err       <= w_v_err_now;
            r_frame_start <= w_v_fall;
            r_locked      <= (w_state_next == StLocked);
            if (p_tick) begin
                r_hs_q <= hsync;
                r_vs_q <= vsync;
                if (w_h_fall) begin
                    r_hcnt     <= '0;
                    r_line_len <= w_hcnt_inc;
                end else if (r_hcnt != CNT_MAX) begin
                    r_hcnt <= w_hcnt_inc;
                end
                // vsync fall takes priority over a coincident hsync fall.
                if (w_v_fall) begin
                    r_vcnt        <= '0;
                    r_frame_lines <= w_vcnt_inc;
                end else if (w_h_fall && (r_vcnt != CNT_MAX)) begin
                    r_vcnt <= w_vcnt_inc;
                end
                // Frame quality is judged at the vsync fall, then restarted.
                if (w_v_fall) begin
                    r_frame_bad <= 1'b0;
                end else if (w_err) begin
                    r_frame_bad <= 1'b1;
                end
            end
        end
    end

`ifdef VGA_RX_STATS_EN
    logic [15:0] r_err_count;
    logic [16:0] w_err_sum;

    assign w_err_sum = {1'b0, r_err_count} + {16'd0, w_h_err_now} + {16'd0, w_v_err_now};

    // Saturating error statistic.
    always_ff @(posedge clk_100MHz) begin
        if (!reset_n) begin
            r_err_count <= '0;
        end else begin
            r_err_count <= w_err_sum[16] ? 16'hFFFF : w_err_sum[15:0];
        end
    end

    assign err_count = r_err_count;
`else
    assign err_count = '0;
`endif

    assign w_h_act = (r_hcnt >= H_BEG) && ({1'b0, r_hcnt} < H_END);
    assign w_v_act = (r_vcnt >= V_BEG) && ({1'b0, r_vcnt} < V_END);
    assign w_act   = w_h_act & w_v_act;

    assign x           = w_act ? (r_hcnt - H_BEG) : '0;
    assign y           = w_act ? (r_vcnt - V_BEG) : '0;
    assign video_on    = r_locked & w_act;
    assign locked      = r_locked;
    assign frame_start = r_frame_start;
    assign h_err       = r_h_err;
    assign v_err       = r_v_err;
    assign line_len    = r_line_len;
    assign frame_lines = r_frame_lines;

endmodule

// File: tb/tb_vga_sync_rx.sv
// Bench for vga_sync_rx on scaled-down timing (40 ticks x 12 lines) with a timestamp-based
// reference model compared every cycle, plus directed literal checks.
module tb_vga_sync_rx;

    localparam int HT = 40;
    localparam int VT = 12;
    localparam int HS = 6;
    localparam int VS = 3;
    localparam int HA = 30;
    localparam int VA = 8;
    localparam int LF = 2;
    localparam int HSW = 4;
    localparam int VSW = 2;
`ifdef VGA_RX_STATS_EN
    localparam int STATS = 1;
`else
    localparam int STATS = 0;
`endif

    logic        clk = 1'b0;
    logic        reset_n, p_tick, hsync, vsync;
    logic [9:0]  x, y, line_len, frame_lines;
    logic        video_on, locked, frame_start, h_err, v_err;
    logic [15:0] err_count;

    always #5 clk = ~clk;

    vga_sync_rx #(
        .H_TOTAL(HT), .V_TOTAL(VT), .H_START(HS), .V_START(VS),
        .LOCK_FRAMES(LF), .H_ACTIVE(HA), .V_ACTIVE(VA)
    ) dut (
        .clk_100MHz(clk), .reset_n(reset_n), .p_tick(p_tick), .hsync(hsync), .vsync(vsync),
        .x(x), .y(y), .video_on(video_on), .locked(locked), .frame_start(frame_start),
        .h_err(h_err), .v_err(v_err), .line_len(line_len), .frame_lines(frame_lines),
        .err_count(err_count)
    );

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: horizontal position is ticks elapsed since the last hsync fall,
    // vertical position is hsync falls seen since the last vsync fall.
    int m_tick, m_href, m_lines, m_line_len, m_frame_lines, m_good, m_errc;
    int m_mode; // 0 searching, 1 acquiring, 2 locked
    bit m_hs_q, m_vs_q, m_bad, e_h_err, e_v_err, e_fs;

    task automatic model_update(input bit rn, input bit pt, input bit hs, input bit vs);
        int hc, vc;
        bit hf, vf, err, clean;
        e_h_err = 0;
        e_v_err = 0;
        e_fs    = 0;
        if (!rn) begin
            m_tick = 0; m_href = 0; m_lines = 0; m_line_len = 0; m_frame_lines = 0;
            m_good = 0; m_errc = 0; m_mode = 0; m_hs_q = 1; m_vs_q = 1; m_bad = 0;
            return;
        end
        if (!pt) return;
        hc = (m_tick - m_href > 1023) ? 1023 : m_tick - m_href;
        vc = (m_lines > 1023) ? 1023 : m_lines;
        hf = m_hs_q && !hs;
        vf = m_vs_q && !vs;
        m_hs_q = hs;
        m_vs_q = vs;
        if (hf) begin
            e_h_err    = (hc + 1 != HT);
            m_line_len = (hc + 1) % 1024;
            m_href     = m_tick + 1;
        end else begin
            e_h_err = (hc == 1022);
        end
        clean = !m_bad && (vc + 1 == VT);
        if (vf) begin
            e_v_err       = (vc + 1 != VT);
            m_frame_lines = (vc + 1) % 1024;
            m_lines       = 0;
            e_fs          = 1;
        end else if (hf) begin
            e_v_err = (vc == 1022);
            m_lines++;
        end
        err = e_h_err || e_v_err;
        if (m_mode == 0) begin
            if (vf) begin m_mode = 1; m_good = 0; end
        end else if (err) begin
            m_mode = 0;
        end else if (m_mode == 1 && vf && clean) begin
            m_good++;
            if (m_good == LF) m_mode = 2;
        end
        if (vf) m_bad = 0;
        else if (err) m_bad = 1;
        if (STATS != 0) begin
            m_errc = m_errc + int'(e_h_err) + int'(e_v_err);
            if (m_errc > 65535) m_errc = 65535;
        end
        m_tick++;
    endtask

    task automatic compare_all();
        int h, v, ex, ey;
        bit act;
        h   = (m_tick - m_href > 1023) ? 1023 : m_tick - m_href;
        v   = (m_lines > 1023) ? 1023 : m_lines;
        act = (h >= HS) && (h < HS + HA) && (v >= VS) && (v < VS + VA);
        ex  = act ? h - HS : 0;
        ey  = act ? v - VS : 0;
        chk("locked", {31'd0, locked}, {31'd0, m_mode == 2});
        chk("frame_start", {31'd0, frame_start}, {31'd0, e_fs});
        chk("h_err", {31'd0, h_err}, {31'd0, e_h_err});
        chk("v_err", {31'd0, v_err}, {31'd0, e_v_err});
        chk("line_len", {22'd0, line_len}, m_line_len);
        chk("frame_lines", {22'd0, frame_lines}, m_frame_lines);
        chk("err_count", {16'd0, err_count}, m_errc);
        chk("x", {22'd0, x}, ex);
        chk("y", {22'd0, y}, ey);
        chk("video_on", {31'd0, video_on}, {31'd0, act && (m_mode == 2)});
    endtask

    always @(negedge clk) begin
        if (chk_en) compare_all();
    end

    // Sync generator state.
    int g_h, g_v, g_len, g_vt, g_vfalls, last_h, last_v, cyc, hold_left;
    bit short_line, short_frame;

    task automatic gen_restart();
        g_h = 0; g_v = 0; g_len = HT; g_vt = VT; last_h = -1; last_v = -1;
    endtask

    task automatic advance();
        if (hold_left > 0) begin
            hold_left--;
            if (hold_left == 0) gen_restart();
            return;
        end
        last_h = g_h;
        last_v = g_v;
        if (g_h == 0 && g_v == 0) g_vfalls++;
        g_h++;
        if (g_h >= g_len) begin
            g_h = 0;
            g_len = short_line ? HT - 1 : HT;
            short_line = 0;
            g_v++;
            if (g_v >= g_vt) begin
                g_v = 0;
                g_vt = short_frame ? VT - 1 : VT;
                short_frame = 0;
            end
        end
    endtask

    // One clock: drive at the falling edge, update model after the rising edge.
    task automatic tick();
        bit pt, hs, vs;
        pt = (cyc % 5) != 4;
        cyc++;
        if (hold_left > 0) begin
            hs = 1; vs = 1;
        end else begin
            hs = (g_h >= HSW); vs = (g_v >= VSW);
        end
        p_tick = pt;
        hsync  = hs;
        vsync  = vs;
        @(posedge clk);
        model_update(reset_n, pt, hs, vs);
        if (pt) advance();
        @(negedge clk);
    endtask

    task automatic run_falls(input int n, input string tag);
        int target, budget;
        target = g_vfalls + n;
        budget = 4000 * n;
        while (g_vfalls < target && budget > 0) begin
            tick();
            budget--;
        end
        chk({tag, "_reached"}, {31'd0, g_vfalls >= target}, 1);
    endtask

    task automatic run_to(input int h, input int v, input string tag);
        int budget;
        budget = 2000;
        while (!(last_h == h && last_v == v) && budget > 0) begin
            tick();
            budget--;
        end
        chk({tag, "_reached"}, {31'd0, last_h == h && last_v == v}, 1);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] ec0;
        int n_herr, budget;
        reset_n = 0; p_tick = 0; hsync = 1; vsync = 1;
        cyc = 0; hold_left = 0; short_line = 0; short_frame = 0; g_vfalls = 0;
        gen_restart();
        @(negedge clk);
        tick();
        chk_en = 1;
        tick();
        chk("rst_locked", {31'd0, locked}, 0);
        chk("rst_line_len", {22'd0, line_len}, 0);
        chk("rst_frame_lines", {22'd0, frame_lines}, 0);
        chk("rst_err_count", {16'd0, err_count}, 0);
        chk("rst_frame_start", {31'd0, frame_start}, 0);
        gen_restart();
        reset_n = 1;

        // Nominal timing: lock one clock after the third vsync fall.
        run_falls(2, "acq");
        chk("lock_before_3rd", {31'd0, locked}, 0);
        run_falls(1, "acq3");
        chk("lock_after_3rd", {31'd0, locked}, 1);
        chk("nom_line_len", {22'd0, line_len}, HT);
        chk("nom_frame_lines", {22'd0, frame_lines}, VT);

        // Active window corners.
        run_to(HS, VS, "win0");
        chk("win0_x", {22'd0, x}, 0);
        chk("win0_y", {22'd0, y}, 0);
        chk("win0_von", {31'd0, video_on}, 1);
        run_to(HS + HA - 1, VS, "winr");
        chk("winr_x", {22'd0, x}, HA - 1);
        run_to(HS + HA, VS, "winpast");
        chk("winpast_von", {31'd0, video_on}, 0);
        chk("winpast_x", {22'd0, x}, 0);

        // One short line: error, lock lost, relock after three more falls.
        short_line = 1;
        run_to(0, VS + 2, "short");
        chk("short_h_err", {31'd0, h_err}, 1);
        chk("short_locked", {31'd0, locked}, 0);
        chk("short_line_len", {22'd0, line_len}, HT - 1);
        tick();
        chk("short_h_err_once", {31'd0, h_err}, 0);
        run_falls(2, "rl1");
        chk("rl1_not_yet", {31'd0, locked}, 0);
        run_falls(1, "rl1b");
        chk("rl1_locked", {31'd0, locked}, 1);

        // Frame one line short.
        ec0 = err_count;
        short_frame = 1;
        run_falls(1, "sf0");
        chk("sf0_frame_lines", {22'd0, frame_lines}, VT);
        run_falls(1, "sf1");
        chk("sf_v_err", {31'd0, v_err}, 1);
        chk("sf_frame_lines", {22'd0, frame_lines}, VT - 1);
        chk("sf_locked", {31'd0, locked}, 0);
        chk("sf_err_delta", {16'd0, err_count - ec0}, STATS);
        run_falls(3, "rl2");
        chk("rl2_locked", {31'd0, locked}, 1);

        // hsync stuck high: saturate, single timeout pulse, back to search.
        hold_left = 1100;
        n_herr = 0;
        budget = 3000;
        while (hold_left > 0 && budget > 0) begin
            tick();
            budget--;
            if (h_err === 1'b1) n_herr++;
        end
        chk("hold_h_err_count", n_herr, 1);
        chk("hold_locked", {31'd0, locked}, 0);
        run_falls(1, "release");
        chk("release_line_len", {22'd0, line_len}, 0);
        chk("release_frame_start", {31'd0, frame_start}, 1);
        run_falls(2, "rl3");
        chk("rl3_locked", {31'd0, locked}, 1);

        // One-clock reset while locked.
        run_to(10, 5, "prerst");
        reset_n = 0;
        tick();
        reset_n = 1;
        chk("mrst_locked", {31'd0, locked}, 0);
        chk("mrst_line_len", {22'd0, line_len}, 0);
        chk("mrst_frame_lines", {22'd0, frame_lines}, 0);
        chk("mrst_err_count", {16'd0, err_count}, 0);
        chk("mrst_von", {31'd0, video_on}, 0);
        chk("mrst_h_err", {31'd0, h_err}, 0);
        run_falls(2, "rl4");
        chk("rl4_not_yet", {31'd0, locked}, 0);
        run_falls(1, "rl4b");
        chk("rl4_locked", {31'd0, locked}, 1);

        tick();
        chk_en = 0;
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
